// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with a two-flop input synchroniser,
// a mid-bit sampling FSM and a one-entry valid/ready output buffer.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // Terminal counts: half a bit to reach the start-bit centre, a full bit after that.
  localparam logic [11:0] HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);

  state_t      state_q,      state_d;
  logic [11:0] cnt_q,        cnt_d;
  logic [2:0]  idx_q,        idx_d;
  logic [7:0]  shift_q,      shift_d;
  logic        rx_meta_q,    rx_meta_d;
  logic        rx_sync_q,    rx_sync_d;
  logic [7:0]  data_out_q,   data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_err_q,  frame_err_d;
  logic        overrun_q,    overrun_d;
  logic        deliver_s;

  // All state registers, with synchronous active-low reset; synchroniser idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 12'd0;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic: synchroniser, receive FSM and output buffer handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    rx_meta_d    = rx_in;
    rx_sync_d    = rx_meta_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    deliver_s    = 1'b0;

    if (!ena) begin
      // Receiver parked; buffer below still drains.
      state_d = ST_IDLE;
      cnt_d   = 12'd0;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = 12'd0;
          if (!rx_sync_q) begin
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = 12'd0;
            if (!rx_sync_q) begin
              state_d = ST_DATA;
              idx_d   = 3'd0;
            end else begin
              // Line went back high before the start-bit centre: treat as a glitch.
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = 12'd0;
            shift_d = {rx_sync_q, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              state_d = ST_STOP;
              idx_d   = 3'd0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = 12'd0;
            if (rx_sync_q) begin
              deliver_s = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
        ST_WAIT_HIGH: begin
          cnt_d = 12'd0;
          if (rx_sync_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_HIGH;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 12'd0;
          idx_d   = 3'd0;
        end
      endcase
    end

    // One-entry buffer: a new byte may replace one that transfers in the same cycle.
    if (deliver_s) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end else begin
      data_valid_d = data_valid_q;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
